// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory arbiter: state encoding and
// default bus widths.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_D = 2'd1,
    ARB_SERVE_I = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_watchdog.sv
// Watchdog for the arbiter's SERVE states. The count is cleared while the
// arbiter is idle and advances on every serve cycle that sees no ack. The
// expiry pulse fires in the TIMEOUT_CYC-th consecutive cycle without an ack.
module arb_watchdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expire_o = en_i & (cnt_q == LAST);

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and the
// data stage. Data accesses always win; the waiting stage sees a stall. A
// req/ack handshake supports variable-latency memory, and a watchdog aborts
// any access that never gets acknowledged.
// Optional feature macro: MEM_ARB_PERF_EN adds the perf_fetch_stall counter.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 255
) (
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]       perf_fetch_stall,
`endif
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              stall_fetch,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              timeout_err
);

  arb_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              timeout_err_q, timeout_err_d;

  logic serving;
  logic wd_expire;
  logic done;
  logic abort;

  assign serving = (state_q != ARB_IDLE);

  // The watchdog only runs while waiting on memory; an ack in the same cycle
  // as expiry counts as a normal completion.
  arb_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (reset),
    .clr_i    (~serving),
    .en_i     (serving & ~mem_ack),
    .expire_o (wd_expire)
  );

  assign done  = serving & (mem_ack | wd_expire);
  assign abort = serving & wd_expire;

  // Completion strobes and read data; data is zero outside the completion
  // cycle and on an aborted access.
  always_comb begin
    if_valid = (state_q == ARB_SERVE_I) & done;
    dm_valid = (state_q == ARB_SERVE_D) & done;
    if_rdata = ((state_q == ARB_SERVE_I) && mem_ack) ? mem_rdata : '0;
    dm_rdata = ((state_q == ARB_SERVE_D) && mem_ack) ? mem_rdata : '0;
  end

  assign stall_fetch = if_req & ~if_valid;
  assign stall_mem   = dm_req & ~dm_valid;

  // Grant and completion decisions. Requests are sampled only in IDLE, so
  // requester changes during a serve are invisible to memory.
  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    timeout_err_d = timeout_err_q | abort;
    case (state_q)
      ARB_IDLE: begin
        if (dm_req) begin
          state_d     = ARB_SERVE_D;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
        end else if (if_req) begin
          state_d     = ARB_SERVE_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
        end
      end
      ARB_SERVE_D, ARB_SERVE_I: begin
        if (done) begin
          state_d   = ARB_IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = ARB_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // FSM state and registered memory-side outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ARB_IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign timeout_err = timeout_err_q;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_q;

  // Saturating count of cycles in which fetch is stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_q <= '0;
    end else if (stall_fetch && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_fetch_stall = perf_q;
`endif

endmodule
